// File: rtl/imem_fetch_port.sv
// Registered instruction-memory fetch port: valid/ready request and response
// handshakes, programmable wait states, per-response fault flags, word load port.
module imem_fetch_port #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 32,
    parameter logic [31:0] TEXT_BASE   = 32'h0000_3000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [1:0]        resp_fault,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              busy
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [31:0]       off_q;
    logic [31:0]       off_in;
    logic [31:0]       sel_off;
    logic              accept;
    logic              resp_load;
    logic              misalign;
    logic              out_range;
    logic [ADDR_W-1:0] rd_idx;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (load_en && state == ST_IDLE)
            mem[load_addr] <= load_data;
    end

    // With zero wait states the read happens on the acceptance edge itself,
    // so the offset must come straight from the request rather than off_q.
    always_comb begin
        off_in    = req_addr - TEXT_BASE;
        sel_off   = (state == ST_IDLE) ? off_in : off_q;
        misalign  = (sel_off[1:0] != 2'b00);
        out_range = |sel_off[31:ADDR_W+2];
        rd_idx    = sel_off[ADDR_W+1:2];
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        resp_load = 1'b0;
        req_ready = (state == ST_IDLE) && !load_en;
        accept    = req_ready && req_valid;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_INIT == 4'd0) begin
                        state_n   = ST_RESP;
                        resp_load = 1'b1;
                    end else begin
                        state_n = ST_WAIT;
                        cnt_n   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_n   = ST_RESP;
                    resp_load = 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            off_q      <= '0;
            resp_data  <= '0;
            resp_fault <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept)
                off_q <= off_in;
            if (resp_load) begin
                resp_fault <= {out_range, misalign};
                resp_data  <= (out_range || misalign) ? '0 : mem[rd_idx];
            end
        end
    end

    assign resp_valid = (state == ST_RESP);
    assign busy       = (state != ST_IDLE);

endmodule

// File: doc/imem_fetch_port.md
# imem_fetch_port

Parametrised, wait-state-capable instruction memory for the multi-cycle CPU. It replaces the combinational word-lookup instruction memory with a registered fetch port. Fetches use a valid/ready request handshake and a valid/ready response handshake, with a programmable access latency. Each response carries alignment and range fault flags. A word-write load port fills program memory before or between fetches.

## Interface
- `ADDR_W`, 10: word-index width; depth = 2^ADDR_W words.
- `DATA_W`, 32: instruction word width.
- `TEXT_BASE`, 32'h0000_3000: byte address of word 0.
- `WAIT_CYCLES`, 1: extra access cycles, legal range 0..15.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  1: fetch request present.
- `req_ready`  out  1: fetch request accepted this cycle when high with `req_valid`.
- `req_addr`  in  32: byte address of the fetch.
- `resp_valid`  out  1: response word is valid.
- `resp_ready`  in  1: consumer takes the response.
- `resp_data`  out  DATA_W: fetched instruction.
- `resp_fault`  out  2: bit0 = misaligned, bit1 = out of range.
- `load_en`  in  1: write `load_data` to word `load_addr` this cycle.
- `load_addr`  in  ADDR_W: word index for load.
- `load_data`  in  DATA_W: word to write.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: `req_ready` = !`load_en`.
  - WAIT: count down the access cycles.
  - RESP: hold the response until it is taken.
- Fetch handshake: a fetch is accepted on a cycle with `req_valid` & `req_ready`. On acceptance:
  - latch offset = `req_addr` − `TEXT_BASE` (32-bit modulo subtraction);
  - latch the faults;
  - load the wait counter with `WAIT_CYCLES`.
- IDLE transitions after acceptance: go to RESP if `WAIT_CYCLES` = 0, else go to WAIT.
- WAIT: decrement the counter each cycle; on the cycle the counter is 1, go to RESP.
- Memory read: synchronous, index = offset[ADDR_W+1:2]. `resp_data` is registered on entry to RESP.
- Faults:
  - misaligned = offset[1:0] ≠ 0;
  - out of range = offset ≥ 4·2^ADDR_W. Addresses below `TEXT_BASE` wrap to a large offset and are therefore out of range.
  - When any fault bit is set, `resp_data` = 0.
- RESP: `resp_valid` = 1. `resp_data` and `resp_fault` stay stable until `resp_valid` & `resp_ready`, then go to IDLE. A new request cannot be accepted in that same cycle; the next acceptance is the following cycle at the earliest.
- Load port: writes happen only in IDLE. `load_en` outside IDLE is ignored and produces no write.
- Load/fetch collision in IDLE: `load_en` has priority and `req_ready` = 0 for that cycle.
- Memory contents are not cleared by reset.

## Timing
- Reset (`rst` low, asynchronous), outputs:
  - state = IDLE;
  - `resp_valid` = 0, `resp_data` = 0, `resp_fault` = 0, `busy` = 0;
  - `req_ready` = 1 once `rst` is high.
- Latency: acceptance at edge N gives `resp_valid` high after edge N+1+`WAIT_CYCLES`.
  - `WAIT_CYCLES` = 0: visible one cycle after acceptance.
  - `WAIT_CYCLES` = 3: visible four cycles after acceptance.
- Throughput: at most one fetch per (`WAIT_CYCLES` + 2) cycles with `resp_ready` held high.
- Backpressure: `resp_valid` stays high indefinitely while `resp_ready` = 0. Data must not change during the stall.
- Reset mid-fetch (in WAIT or RESP): the in-flight fetch is dropped and no response is ever produced for it. Outputs go to their reset values immediately, without waiting for a clock edge.
- A load in IDLE is visible to a fetch accepted on the next cycle.

## Test plan
- **Load and basic fetch:** with `WAIT_CYCLES` = 0, load word 5 = 32'h2010_0007, then fetch 32'h0000_3014. Required: `resp_valid` one cycle after acceptance, `resp_data` = 32'h2010_0007, `resp_fault` = 0.
- **Latency:** with `WAIT_CYCLES` = 3, fetch 32'h0000_3000. Required: `resp_valid` rises exactly four cycles after acceptance, and `busy` is high for every intervening cycle.
- **Faults:**
  - fetch 32'h0000_3002: `resp_fault` = 2'b01, `resp_data` = 0;
  - fetch 32'h0000_4000 with `ADDR_W` = 10: `resp_fault` = 2'b10;
  - fetch 32'h0000_2FFC: `resp_fault` = 2'b10.
- **Backpressure:** hold `resp_ready` = 0 for 5 cycles. Required: `resp_valid` and `resp_data` are unchanged, `req_ready` = 0 throughout, and the FSM returns to IDLE only on the cycle after `resp_ready` = 1.
- **Load priority:** assert `load_en` (word 0 = 32'hDEAD_BEEF) together with `req_valid`. Required: `req_ready` = 0 on that cycle; the fetch is accepted on the next cycle and returns 32'hDEAD_BEEF. Also, `load_en` asserted during WAIT leaves the memory unchanged.
- **Reset mid-operation:** pull `rst` low in WAIT. Required: `resp_valid` = 0, `resp_data` = 0 and `busy` = 0 asynchronously; after release, no stale response appears and a new fetch completes normally.
